// File: rtl/buf_loader_pkg.sv
// Shared command codes, response bytes and FSM encodings for the program-buffer loader.
package buf_loader_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_START = 8'h02;
   localparam logic [7:0] CMD_ABORT = 8'h03;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   localparam int unsigned WORD_BYTES = 5;

   typedef enum logic [2:0] {
      S_SYNC,
      S_CMD,
      S_ADDR_H,
      S_ADDR_L,
      S_COUNT,
      S_DATA,
      S_CSUM,
      S_RESP
   } state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/buf_loader_byte_timeout.sv
// Inter-byte idle counter: expired rises once TIMEOUT_CYCLES clocks pass with no kick.
module byte_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic kick,
   input  logic clr,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   // Counter freezes once expired so the flag stays up until kicked or cleared.
   always_ff @(posedge clk) begin
      if (rst || clr || kick) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (!expired) begin
         cnt     <= cnt + CW'(1);
         expired <= (cnt == CW'(TIMEOUT_CYCLES - 1));
      end
   end

endmodule

// File: rtl/buf_loader.sv
// Host-link frame parser that fills the program buffer and issues executor start/abort.
module buf_loader
   import buf_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] ext_buffer_addr,
   output logic [39:0] ext_buffer_data,
   output logic        ext_buffer_wr,
   output logic        start,
   output logic [15:0] start_addr,
   output logic        abort,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  err_count
);

   state_t      state, state_nx;
   logic [7:0]  csum, csum_nx;
   logic [7:0]  cmd, cmd_nx;
   logic [15:0] addr, addr_nx;
   logic [8:0]  words_left, words_left_nx;
   logic [2:0]  byte_cnt, byte_cnt_nx;
   logic [31:0] word, word_nx;

   logic [15:0] ext_buffer_addr_nx;
   logic [39:0] ext_buffer_data_nx;
   logic        ext_buffer_wr_nx, start_nx, abort_nx, tx_valid_nx;
   logic [15:0] start_addr_nx;
   logic [7:0]  tx_data_nx, err_count_nx;

   logic timer_clr, timer_expired;

   assign timer_clr = (state == S_SYNC) || (state == S_RESP);

   byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .kick    (rx_valid),
      .clr     (timer_clr),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_SYNC;
         csum            <= '0;
         cmd             <= '0;
         addr            <= '0;
         words_left      <= '0;
         byte_cnt        <= '0;
         word            <= '0;
         ext_buffer_addr <= '0;
         ext_buffer_data <= '0;
         ext_buffer_wr   <= 1'b0;
         start           <= 1'b0;
         start_addr      <= '0;
         abort           <= 1'b0;
         tx_data         <= '0;
         tx_valid        <= 1'b0;
         err_count       <= '0;
      end else begin
         state           <= state_nx;
         csum            <= csum_nx;
         cmd             <= cmd_nx;
         addr            <= addr_nx;
         words_left      <= words_left_nx;
         byte_cnt        <= byte_cnt_nx;
         word            <= word_nx;
         ext_buffer_addr <= ext_buffer_addr_nx;
         ext_buffer_data <= ext_buffer_data_nx;
         ext_buffer_wr   <= ext_buffer_wr_nx;
         start           <= start_nx;
         start_addr      <= start_addr_nx;
         abort           <= abort_nx;
         tx_data         <= tx_data_nx;
         tx_valid        <= tx_valid_nx;
         err_count       <= err_count_nx;
      end
   end

   always_comb begin
      state_nx           = state;
      csum_nx            = csum;
      cmd_nx             = cmd;
      addr_nx            = addr;
      words_left_nx      = words_left;
      byte_cnt_nx        = byte_cnt;
      word_nx            = word;
      ext_buffer_addr_nx = ext_buffer_addr;
      ext_buffer_data_nx = ext_buffer_data;
      ext_buffer_wr_nx   = 1'b0;
      start_nx           = 1'b0;
      start_addr_nx      = start_addr;
      abort_nx           = 1'b0;
      tx_data_nx         = tx_data;
      tx_valid_nx        = tx_valid;
      err_count_nx       = err_count;

      // Payload bytes feed the checksum; the CSUM byte itself is compared, not summed.
      if (rx_valid && (state inside {S_CMD, S_ADDR_H, S_ADDR_L, S_COUNT, S_DATA}))
         csum_nx = csum + rx_data;

      if (timer_expired && !timer_clr) begin
         state_nx     = S_SYNC;
         err_count_nx = sat_inc(err_count);
      end else begin
         case (state)
            S_SYNC: begin
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  state_nx = S_CMD;
                  csum_nx  = '0;
               end
            end
            S_CMD: begin
               if (rx_valid) begin
                  cmd_nx = rx_data;
                  case (rx_data)
                     CMD_WRITE, CMD_START: state_nx = S_ADDR_H;
                     CMD_ABORT:            state_nx = S_CSUM;
                     default: begin
                        state_nx     = S_RESP;
                        tx_data_nx   = RSP_NAK;
                        tx_valid_nx  = 1'b1;
                        err_count_nx = sat_inc(err_count);
                     end
                  endcase
               end
            end
            S_ADDR_H: begin
               if (rx_valid) begin
                  addr_nx[15:8] = rx_data;
                  state_nx      = S_ADDR_L;
               end
            end
            S_ADDR_L: begin
               if (rx_valid) begin
                  addr_nx[7:0] = rx_data;
                  state_nx     = (cmd == CMD_WRITE) ? S_COUNT : S_CSUM;
               end
            end
            S_COUNT: begin
               if (rx_valid) begin
                  words_left_nx = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                  byte_cnt_nx   = '0;
                  state_nx      = S_DATA;
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  word_nx = {word[23:0], rx_data};
                  if (byte_cnt == 3'(WORD_BYTES - 1)) begin
                     byte_cnt_nx        = '0;
                     ext_buffer_wr_nx   = 1'b1;
                     ext_buffer_data_nx = {word, rx_data};
                     ext_buffer_addr_nx = addr;
                     addr_nx            = addr + 16'd1;
                     words_left_nx      = words_left - 9'd1;
                     if (words_left == 9'd1)
                        state_nx = S_CSUM;
                  end else begin
                     byte_cnt_nx = byte_cnt + 3'd1;
                  end
               end
            end
            S_CSUM: begin
               if (rx_valid) begin
                  state_nx    = S_RESP;
                  tx_valid_nx = 1'b1;
                  if (rx_data == csum) begin
                     tx_data_nx = RSP_ACK;
                     if (cmd == CMD_START) begin
                        start_nx      = 1'b1;
                        start_addr_nx = addr;
                     end
                     if (cmd == CMD_ABORT)
                        abort_nx = 1'b1;
                  end else begin
                     tx_data_nx   = RSP_NAK;
                     err_count_nx = sat_inc(err_count);
                  end
               end
            end
            S_RESP: begin
               // Incoming bytes are ignored until the response drains.
               if (tx_ready) begin
                  tx_valid_nx = 1'b0;
                  state_nx    = S_SYNC;
               end
            end
            default: state_nx = S_SYNC;
         endcase
      end
   end

endmodule
